// File: rtl/bcd_converter_seq_if.sv
// Handshake and display bus between the ALU-side controller and the BCD converter.
// The master drives start/result; the converter (slave) drives status and digits.
interface bcd_converter_seq_if;
  logic        start;
  logic [19:0] result;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  numberBits [0:3];

  modport master (
    output start, result,
    input  busy, done, ovf, numberBits
  );

  modport slave (
    input  start, result,
    output busy, done, ovf, numberBits
  );
endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble converter: 20-bit binary to four saturated BCD digits
// plus an overflow flag, one shift step per clock, 22 cycles per conversion.
module bcd_converter_seq (
  input logic              clk,
  input logic              rst_n,
  bcd_converter_seq_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]  state_reg;
  logic [19:0] shift_reg;
  logic [27:0] acc_reg;
  logic [4:0]  count_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ovf_reg;
  logic [3:0]  digits_reg [0:3];

  logic [27:0] acc_adj;
  logic [27:0] acc_next;
  logic [19:0] shift_next;
  logic        ovf_next;

  // Add-3 correction on every accumulator digit before the shift.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  assign {acc_next, shift_next} = {acc_adj[26:0], shift_reg, 1'b0};
  assign ovf_next = |acc_next[27:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < 4; i++) digits_reg[i] <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            shift_reg <= bus.result;
            acc_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_next;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd19) begin
            // Last step: publish the post-shift digits, saturating on overflow.
            ovf_reg  <= ovf_next;
            for (int i = 0; i < 4; i++)
              digits_reg[i] <= ovf_next ? 4'd9 : acc_next[(3-i)*4 +: 4];
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.ovf  = ovf_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      assign bus.numberBits[gi] = digits_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Self-checking bench for bcd_converter_seq: directed scenarios plus random
// values checked against a decimal arithmetic reference model.
module tb_bcd_converter_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  bcd_converter_seq_if bus ();

  bcd_converter_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.numberBits[0], bus.numberBits[1], bus.numberBits[2], bus.numberBits[3]};
  endfunction

  // Reference: decimal digits by arithmetic, saturated to 9999 above that.
  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic convert(input logic [19:0] v, input string tag);
    int          lat;
    logic        busy_ok;
    logic [16:0] exp;
    exp = model(int'(v));
    @(negedge clk);
    bus.start  = 1'b1;
    bus.result = v;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.result = 20'($urandom);
    chk({tag, "_busy_at_accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd20);
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_digits"}, 32'(digits()), 32'(exp[15:0]));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[16]));
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          ndone;
    int          done_edge [$];
    logic [19:0] v;

    bus.start  = 1'b0;
    bus.result = '0;
    rst_n      = 1'b0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    chk("reset_digits", 32'(digits()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary conversions.
    convert(20'd1234, "basic_1234");
    repeat (5) @(posedge clk);
    #1;
    chk("hold_1234", 32'(digits()), 32'h1234);
    convert(20'd0, "bound_0");
    convert(20'd9999, "bound_9999");
    convert(20'd10000, "bound_10000");
    convert(20'hFFFFF, "bound_max");

    // Busy rejection: starts at N+5 and N+20 must be ignored.
    ndone = 0;
    done_edge.delete();
    for (int e = 0; e <= 50; e++) begin
      @(negedge clk);
      bus.start  = (e == 0 || e == 5 || e == 20);
      bus.result = (e == 0) ? 20'd42 : 20'd777;
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        done_edge.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("reject_done_count", 32'(ndone), 32'd1);
    if (done_edge.size() > 0) chk("reject_done_edge", 32'(done_edge[0]), 32'd20);
    chk("reject_digits", 32'(digits()), 32'h0042);

    // Continuous start: done every 22 cycles.
    done_edge.delete();
    bus.start  = 1'b1;
    bus.result = 20'd500;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_edge.push_back(e);
        chk("cont_digits", 32'(digits()), 32'h0500);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("cont_done_count", 32'(done_edge.size()), 32'd3);
    for (int i = 1; i < done_edge.size(); i++)
      chk("cont_spacing", 32'(done_edge[i] - done_edge[i-1]), 32'd22);
    repeat (25) @(posedge clk);

    // Mid-conversion reset aborts 8765.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.result = 20'd8765;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    chk("midrst_digits", 32'(digits()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    convert(20'd8765, "after_rst_8765");

    // Random sweep around the decimal range and across the full input width.
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       v = 20'($urandom_range(0, 10100));
        1:       v = 20'($urandom_range(9990, 10010));
        default: v = 20'($urandom);
      endcase
      convert(v, $sformatf("rand_%0d", v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
